// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - Mode-0 SPI byte transceiver below the flash command controller
module spi_byte_engine #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       sclk,
  input  logic       srst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_do,
  input  logic       spi_di
);

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_N = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
  localparam int CW    = $clog2(MAX_N) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    WAIT  = 3'd4,
    HOLD  = 3'd5,
    GAP   = 3'd6
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          last_q;
  logic          accept;
  logic          cnt_done;

  assign accept   = tx_valid && tx_ready;
  assign cnt_done = (cnt == '0);
  assign bit_nxt  = bit_cnt - 3'd1;

  // Next-state and decoded outputs; tx_ready is held low while reset is asserted
  always_comb begin
    state_n  = state;
    tx_ready = 1'b0;
    spi_clk  = 1'b0;
    spi_cs   = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        spi_cs   = 1'b1;
        busy     = 1'b0;
        tx_ready = !srst;
        if (tx_valid && !srst) state_n = SETUP;
      end
      SETUP: begin
        if (cnt_done) state_n = LOW;
      end
      LOW: begin
        if (cnt_done) state_n = HIGH;
      end
      HIGH: begin
        spi_clk = 1'b1;
        if (cnt_done) begin
          if (bit_cnt != 3'd0) state_n = LOW;
          else if (last_q)     state_n = HOLD;
          else                 state_n = WAIT;
        end
      end
      WAIT: begin
        tx_ready = !srst;
        if (tx_valid && !srst) state_n = LOW;
      end
      HOLD: begin
        if (cnt_done) state_n = GAP;
      end
      GAP: begin
        spi_cs  = 1'b1;
        busy    = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register, phase counter and shift datapath
  always_ff @(posedge sclk) begin
    if (srst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= 3'd7;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      last_q   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      spi_do   <= 1'b0;
    end else begin
      state    <= state_n;
      rx_valid <= 1'b0;

      // each timed state loads its length on entry and counts down to zero
      if (state_n != state) begin
        case (state_n)
          SETUP:    cnt <= CW'(CS_SETUP - 1);
          LOW:      cnt <= CW'(CLK_DIV - 1);
          HIGH:     cnt <= CW'(CLK_DIV - 1);
          HOLD:     cnt <= CW'(CS_HOLD - 1);
          default:  cnt <= '0;
        endcase
      end else if (!cnt_done) begin
        cnt <= cnt - 1'b1;
      end

      if (accept) begin
        tx_sh   <= tx_data;
        last_q  <= tx_last;
        bit_cnt <= 3'd7;
        spi_do  <= tx_data[7];
      end

      // falling spi_clk edge: advance to the next bit to drive
      if (state == HIGH && state_n == LOW) begin
        bit_cnt <= bit_nxt;
        spi_do  <= tx_sh[bit_nxt];
      end

      // rising spi_clk edge: capture MISO
      if (state == LOW && state_n == HIGH) begin
        rx_sh <= {rx_sh[6:0], spi_di};
      end

      if (state == HIGH && cnt_done && bit_cnt == 3'd0) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule
